button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter CNT_MAX, 500000, number of consecutive stable synchronized samples required to accept a new button level (10 ms at 50 MHz).
REQ-003 Parameter CNT_W, 20, counter width; SHALL satisfy 2^CNT_W > CNT_MAX.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 buttons_raw  input  3  raw push-buttons, asynchronous, active-low (0 = pressed); bit0 gen, bit1 encrypt, bit2 decrypt.
REQ-007 buttons  output  3  debounced button levels, active-low; feeds the downstream gen/encrypt/decrypt command decoder.
REQ-008 press  output  3  one-cycle high pulse per bit when that debounced bit goes 1->0.
REQ-009 release  output  3  one-cycle high pulse per bit when that debounced bit goes 0->1.
REQ-010 multi  output  1  high while more than one debounced bit is low.

Function
REQ-011 Each raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Each bit SHALL be debounced independently with its own CNT_W-bit counter; no cross-bit interaction except multi.
REQ-013 Per-bit FSM states: IDLE_HI (debounced 1, sync2 1), CHK_LO (debounced 1, sync2 0, counting), HELD_LO (debounced 0, sync2 0), CHK_HI (debounced 0, sync2 1, counting).
REQ-014 IDLE_HI -> CHK_LO when sync2 = 0; counter loads 1.
REQ-015 CHK_LO: sync2 = 0 -> counter increments; sync2 = 1 -> back to IDLE_HI, counter cleared (bounce rejected).
REQ-016 CHK_LO -> HELD_LO on the cycle counter = CNT_MAX and sync2 = 0; debounced bit becomes 0, counter cleared.
REQ-017 HELD_LO / CHK_HI SHALL mirror REQ-014..016 with polarities swapped.
REQ-018 Counter SHALL saturate logic-wise: it never exceeds CNT_MAX and never wraps.
REQ-019 Latency: a raw level held steady SHALL appear on buttons exactly CNT_MAX+2 clock edges after the first edge that samples it into sync1.
REQ-020 press[i] SHALL be registered and high for exactly the one cycle in which buttons[i] first reads 0; release[i] likewise for 0->1.
REQ-021 press and release for the same bit SHALL never be high in the same cycle.
REQ-022 Simultaneous transitions on several bits SHALL be handled independently; several press bits may pulse in the same cycle.
REQ-023 multi SHALL be a registered function of buttons, updating in the same cycle as buttons.
REQ-024 Any pulse shorter than CNT_MAX synchronized cycles SHALL produce no change on buttons, press, release or multi.

Reset
REQ-025 While rst_n = 0: sync1, sync2, buttons = 3'b111; press, release = 3'b000; multi = 0; all counters 0; all FSMs IDLE_HI.
REQ-026 Reset assertion mid-count SHALL abort the count without emitting press or release.
REQ-027 After rst_n deasserts with a button already held, the press SHALL be accepted CNT_MAX+2 edges later with a normal press pulse.

Verification (CNT_MAX = 4)
REQ-028 Reset with buttons_raw = 3'b111 -> buttons = 3'b111, press = release = 0, multi = 0 throughout.
REQ-029 buttons_raw 3'b111 -> 3'b110 held -> buttons = 3'b110 exactly 6 edges after sampling; press = 3'b001 for one cycle.
REQ-030 bit1 low for 3 cycles then high, repeated 5 times -> buttons stays 3'b111, no pulses.
REQ-031 From 3'b110 stable, raw -> 3'b100 -> buttons 3'b100, press = 3'b010 one cycle, multi = 1; raw -> 3'b111 -> release = 3'b011 one cycle, multi = 0.
REQ-032 rst_n pulsed low at count 3 of a bit2 press -> no press pulse; with raw still 3'b011, buttons = 3'b011 6 edges after rst_n release.

Source files
------------

// File: rtl/button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Three-channel push-button debouncer. Each active-low raw input
//             is synchronised through two flops, then qualified by its own
//             counter-based state machine. A new level is accepted only after
//             CNT_MAX+1 consecutive identical synchronised samples. Accepted
//             edges produce one-cycle press/release pulses.
//  Ports    :
//    clk           in   1  system clock, rising edge
//    rst_n         in   1  asynchronous active-low reset
//    buttons_raw   in   3  raw buttons, asynchronous, active-low
//                          (bit0 gen, bit1 encrypt, bit2 decrypt)
//    buttons       out  3  debounced levels, active-low
//    press         out  3  one-cycle pulse when a debounced bit goes 1->0
//    release_pulse out  3  one-cycle pulse when a debounced bit goes 0->1
//                          ("release" itself is a reserved word)
//    multi         out  1  high while more than one debounced bit is low
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce #(
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] buttons_raw,
    output logic [2:0] buttons,
    output logic [2:0] press,
    output logic [2:0] release_pulse,
    output logic       multi
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_HI = 2'd0,   // debounced 1, input 1
        CHK_LO  = 2'd1,   // debounced 1, input 0, counting
        HELD_LO = 2'd2,   // debounced 0, input 0
        CHK_HI  = 2'd3    // debounced 0, input 1, counting
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous button inputs
    // ------------------------------------------------------------------
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= buttons_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-cycle debounced levels, gathered so multi can be registered in
    // the same cycle that buttons changes.
    logic [2:0] w_btn_nxt;

    // ------------------------------------------------------------------
    // Independent per-bit debounce state machines
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_bit
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_btn;
        logic             w_btn_bit;
        logic             r_press;
        logic             w_press_bit;
        logic             r_rel;
        logic             w_rel_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE_HI;
                r_cnt   <= '0;
                r_btn   <= 1'b1;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_btn   <= w_btn_bit;
                r_press <= w_press_bit;
                r_rel   <= w_rel_bit;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_btn_bit   = r_btn;
            w_press_bit = 1'b0;
            w_rel_bit   = 1'b0;
            case (r_state)
                IDLE_HI: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = CHK_LO;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                CHK_LO: begin
                    if (r_sync2[i]) begin
                        // bounce: discard the partial count
                        w_state_nxt = IDLE_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_cnt_max) begin
                        // >= keeps the counter from ever passing CNT_MAX
                        w_state_nxt = HELD_LO;
                        w_cnt_nxt   = '0;
                        w_btn_bit   = 1'b0;
                        w_press_bit = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                HELD_LO: begin
                    if (r_sync2[i]) begin
                        w_state_nxt = CHK_HI;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                CHK_HI: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = HELD_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_cnt_max) begin
                        w_state_nxt = IDLE_HI;
                        w_cnt_nxt   = '0;
                        w_btn_bit   = 1'b1;
                        w_rel_bit   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_btn_bit   = 1'b1;
                end
            endcase
        end

        assign w_btn_nxt[i]     = w_btn_bit;
        assign buttons[i]       = r_btn;
        assign press[i]         = r_press;
        assign release_pulse[i] = r_rel;
    end

    // ------------------------------------------------------------------
    // multi: at least two of the three next-cycle levels are low
    // ------------------------------------------------------------------
    logic [2:0] w_low_nxt;
    logic       r_multi;

    assign w_low_nxt = ~w_btn_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi <= 1'b0;
        end else begin
            r_multi <= (w_low_nxt[0] & w_low_nxt[1]) |
                       (w_low_nxt[0] & w_low_nxt[2]) |
                       (w_low_nxt[1] & w_low_nxt[2]);
        end
    end

    assign multi = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_button_debounce
//  Purpose  : Self-checking bench for button_debounce with CNT_MAX = 4.
//             Directed scenarios followed by randomised bouncing inputs, all
//             compared every cycle against a window-based reference model:
//             a debounced bit takes value v once the last CNT_MAX+1
//             synchronised samples are all v.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_debounce;

    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;
    localparam int WIN     = CNT_MAX + 1;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic [2:0] buttons_raw = 3'b111;
    logic [2:0] buttons;
    logic [2:0] press;
    logic [2:0] release_pulse;
    logic       multi;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [2:0] m_p1, m_p2;
    logic [2:0] m_btn, m_press, m_rel;
    logic       m_multi;
    logic [2:0] m_win[$];

    button_debounce #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buttons_raw   (buttons_raw),
        .buttons       (buttons),
        .press         (press),
        .release_pulse (release_pulse),
        .multi         (multi)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_p1    = 3'b111;
        m_p2    = 3'b111;
        m_btn   = 3'b111;
        m_press = 3'b000;
        m_rel   = 3'b000;
        m_multi = 1'b0;
        m_win.delete();
    endfunction

    // One rising edge of the reference model.
    task automatic model_edge();
        logic [2:0] seen;
        logic       v;
        bit         all_v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_p2;
        m_p2 = m_p1;
        m_p1 = buttons_raw;
        m_win.push_back(seen);
        if (m_win.size() > WIN) void'(m_win.pop_front());
        m_press = 3'b000;
        m_rel   = 3'b000;
        if (m_win.size() == WIN) begin
            for (int b = 0; b < 3; b++) begin
                v     = ~m_btn[b];
                all_v = 1'b1;
                foreach (m_win[j]) if (m_win[j][b] != v) all_v = 1'b0;
                if (all_v) begin
                    m_btn[b] = v;
                    if (v == 1'b0) m_press[b] = 1'b1;
                    else           m_rel[b]   = 1'b1;
                end
            end
        end
        m_multi = ($countones(~m_btn) > 1);
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_model();
        check("buttons", buttons, m_btn);
        check("press", press, m_press);
        check("release", release_pulse, m_rel);
        check("multi", {2'b00, multi}, {2'b00, m_multi});
    endtask

    // Drive raw, take one rising edge, then compare on the falling edge.
    task automatic cycle(input logic [2:0] raw);
        buttons_raw = raw;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    // Assert reset away from a clock edge, hold it for n edges, then release
    // it mid low phase so the next rising edge is the first live sample.
    task automatic apply_reset(input logic [2:0] raw, input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        repeat (n) cycle(raw);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] r;

        // reset with idle buttons
        #1;
        apply_reset(3'b111, 3);
        repeat (4) cycle(3'b111);
        check("idle_buttons", buttons, 3'b111);

        // single press on bit0: visible 6 edges after first sample
        for (int k = 1; k <= 7; k++) begin
            cycle(3'b110);
            if (k < 7) check("lat_pre", buttons, 3'b111);
        end
        check("lat_buttons", buttons, 3'b110);
        check("lat_press", press, 3'b001);
        cycle(3'b110);
        check("press_one_cycle", press, 3'b000);

        // back to idle, then bit1 bounces shorter than the window
        repeat (8) cycle(3'b111);
        for (int n = 0; n < 5; n++) begin
            repeat (3) cycle(3'b101);
            repeat (3) cycle(3'b111);
        end
        repeat (4) cycle(3'b111);
        check("bounce_buttons", buttons, 3'b111);

        // two buttons held, then both released together
        repeat (8) cycle(3'b110);
        for (int k = 1; k <= 7; k++) cycle(3'b100);
        check("two_buttons", buttons, 3'b100);
        check("two_press", press, 3'b010);
        check("two_multi", {2'b00, multi}, 3'b001);
        for (int k = 1; k <= 7; k++) cycle(3'b111);
        check("two_release", release_pulse, 3'b011);
        check("two_multi_clr", {2'b00, multi}, 3'b000);

        // reset in the middle of a bit2 count, button kept held
        repeat (4) cycle(3'b111);
        repeat (5) cycle(3'b011);
        apply_reset(3'b011, 1);
        check("abort_press", press, 3'b000);
        for (int k = 1; k <= 7; k++) begin
            cycle(3'b011);
            if (k < 7) check("post_rst_pre", buttons, 3'b111);
        end
        check("post_rst_buttons", buttons, 3'b011);
        check("post_rst_press", press, 3'b100);

        // randomised bouncing on all three bits
        for (int k = 0; k < 900; k++) begin
            r = buttons_raw;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, (k < 400) ? 3 : 11) == 0) r[b] = ~r[b];
            cycle(r);
            if (k == 650) apply_reset(buttons_raw, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
